// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates the ADC end of the serial link driven by adc_fsm.
// The serial pins are oversampled on clk, which must run at least 8x SCLK.
// An 8-bit control byte is decoded from the command bits. Its SEL field
// picks one of NCH parallel sample words. That word is shifted out MSB first
// after a one-bit busy period, during which SSTRB is high.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   CSnot      chip select from the master, active low
//   SCLK       serial clock from the master, idles low
//   DIN        serial command bits, sampled on SCLK rise
//   DOUT       serial result bits, updated on SCLK fall
//   SSTRB      conversion strobe, high for the busy-bit period
//   ch_data    NCH sample words; channel k is at [k*DATA_W +: DATA_W]
//   ctrl_byte  last accepted control byte
//   ctrl_valid one-clk pulse when ctrl_byte updates
//   busy       high from start-bit acceptance until the return to IDLE
`timescale 1ns/1ps
module adc_spi_responder #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned NCH         = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   CSnot,
   input  logic                   SCLK,
   input  logic                   DIN,
   output logic                   DOUT,
   output logic                   SSTRB,
   input  logic [NCH*DATA_W-1:0]  ch_data,
   output logic [7:0]             ctrl_byte,
   output logic                   ctrl_valid,
   output logic                   busy
);

   // The counter tracks both the command bits (8) and the result bits (DATA_W).
   localparam int unsigned CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CTRL,
      S_WAIT,
      S_DATA,
      S_TAIL
   } state_t;

   state_t              state, state_n;
   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
   logic                sclk_d;
   logic                cs_s, sclk_s, din_s, sclk_rise, sclk_fall;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [6:0]          ctrl_sr, ctrl_sr_n;
   logic [7:0]          ctrl_shift;
   logic [DATA_W-1:0]   data_sr, data_sr_n, sel_word;
   logic                dout_n, sstrb_n, busy_n, ctrl_valid_n;
   logic [7:0]          ctrl_byte_n;

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ctrl_shift = {ctrl_sr, din_s};

   // Word selected by the accepted SEL field; channels past NCH read as zero.
   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (32'(ctrl_byte[6:4]) == k) sel_word = ch_data[k*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      ctrl_sr_n    = ctrl_sr;
      data_sr_n    = data_sr;
      dout_n       = DOUT;
      sstrb_n      = SSTRB;
      ctrl_byte_n  = ctrl_byte;
      ctrl_valid_n = 1'b0;

      // A deasserted chip select overrides any SCLK edge seen in the same clk.
      if (cs_s) begin
         state_n = S_IDLE;
         dout_n  = 1'b0;
         sstrb_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               dout_n  = 1'b0;
               sstrb_n = 1'b0;
               if (sclk_rise && din_s) begin
                  state_n   = S_CTRL;
                  cnt_n     = CNT_W'(1);
                  ctrl_sr_n = 7'h01;
               end
            end
            S_CTRL: begin
               if (sclk_rise) begin
                  ctrl_sr_n = ctrl_shift[6:0];
                  cnt_n     = cnt + CNT_W'(1);
                  if (cnt == CNT_W'(7)) begin
                     ctrl_byte_n  = ctrl_shift;
                     ctrl_valid_n = 1'b1;
                     state_n      = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (sclk_fall) begin
                  data_sr_n = sel_word;
                  sstrb_n   = 1'b1;
                  dout_n    = 1'b0;
                  cnt_n     = '0;
                  state_n   = S_DATA;
               end
            end
            S_DATA: begin
               if (sclk_fall) begin
                  sstrb_n = 1'b0;
                  if (cnt == CNT_W'(DATA_W)) begin
                     dout_n  = 1'b0;
                     state_n = S_TAIL;
                  end else begin
                     dout_n    = data_sr[DATA_W-1];
                     data_sr_n = data_sr << 1;
                     cnt_n     = cnt + CNT_W'(1);
                  end
               end
            end
            S_TAIL: begin
               dout_n = 1'b0;
               // A new start bit here begins a back-to-back conversion.
               if (sclk_rise && din_s) begin
                  state_n   = S_CTRL;
                  cnt_n     = CNT_W'(1);
                  ctrl_sr_n = 7'h01;
               end
            end
            default: begin
               state_n = S_IDLE;
               dout_n  = 1'b0;
               sstrb_n = 1'b0;
            end
         endcase
      end

      busy_n = (state_n != S_IDLE);
   end

   // Synchronizers, state register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cs_sync    <= '1;
         sclk_sync  <= '0;
         din_sync   <= '0;
         sclk_d     <= 1'b0;
         state      <= S_IDLE;
         cnt        <= '0;
         ctrl_sr    <= '0;
         data_sr    <= '0;
         DOUT       <= 1'b0;
         SSTRB      <= 1'b0;
         busy       <= 1'b0;
         ctrl_valid <= 1'b0;
         ctrl_byte  <= 8'h00;
      end else begin
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], CSnot};
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         din_sync   <= {din_sync[SYNC_STAGES-2:0], DIN};
         sclk_d     <= sclk_s;
         state      <= state_n;
         cnt        <= cnt_n;
         ctrl_sr    <= ctrl_sr_n;
         data_sr    <= data_sr_n;
         DOUT       <= dout_n;
         SSTRB      <= sstrb_n;
         busy       <= busy_n;
         ctrl_valid <= ctrl_valid_n;
         ctrl_byte  <= ctrl_byte_n;
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder. It acts as the SPI master and drives
// one SCLK half period every 8 clk. Two instances share the pins: an NCH=8
// instance for the general tests, and an NCH=4 instance for the
// out-of-range channel case.
`timescale 1ns/1ps
module tb_adc_spi_responder;

   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        rst, cs_n, sclk, din;
   logic [63:0] ch8;
   logic [31:0] ch4;
   logic        dout8, sstrb8, cv8_sig, busy8;
   logic        dout4, sstrb4, cv4_sig, busy4;
   logic [7:0]  cb8, cb4;
   logic        use4;
   logic        dout, sstrb, busy;
   logic [7:0]  ctrl_byte;
   int          checks = 0;
   int          failures = 0;
   int          cv8 = 0;
   int          cv4 = 0;

   always #5 clk = ~clk;

   adc_spi_responder #(.DATA_W(8), .NCH(8), .SYNC_STAGES(SYNC)) dut8 (
      .clk(clk), .rst(rst), .CSnot(cs_n), .SCLK(sclk), .DIN(din),
      .DOUT(dout8), .SSTRB(sstrb8), .ch_data(ch8), .ctrl_byte(cb8),
      .ctrl_valid(cv8_sig), .busy(busy8));

   adc_spi_responder #(.DATA_W(8), .NCH(4), .SYNC_STAGES(SYNC)) dut4 (
      .clk(clk), .rst(rst), .CSnot(cs_n), .SCLK(sclk), .DIN(din),
      .DOUT(dout4), .SSTRB(sstrb4), .ch_data(ch4), .ctrl_byte(cb4),
      .ctrl_valid(cv4_sig), .busy(busy4));

   assign dout      = use4 ? dout4  : dout8;
   assign sstrb     = use4 ? sstrb4 : sstrb8;
   assign busy      = use4 ? busy4  : busy8;
   assign ctrl_byte = use4 ? cb4    : cb8;

   // Running count of ctrl_valid pulses per instance.
   always @(posedge clk) begin
      if (cv8_sig) cv8 = cv8 + 1;
      if (cv4_sig) cv4 = cv4 + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period: present DIN, rise (master samples DOUT/SSTRB), fall.
   task automatic xfer_bit(input logic d, output logic q, output logic s);
      din = d;
      wait_clk(8);
      sclk = 1'b1;
      q = dout;
      s = sstrb;
      wait_clk(8);
      sclk = 1'b0;
   endtask

   task automatic begin_frame();
      cs_n = 1'b0;
      wait_clk(8);
   endtask

   task automatic end_frame();
      cs_n = 1'b1;
      din  = 1'b0;
      wait_clk(10);
   endtask

   // Full frame: lead zeros, 8 command bits, busy bit, 8 result bits.
   task automatic run_frame(input logic [7:0] cmd, input int lead, input bit perturb,
                            output logic [7:0] res, output logic busybit,
                            output logic s9, output logic s10);
      logic q, s;
      for (int i = 0; i < lead; i++) xfer_bit(1'b0, q, s);
      for (int i = 7; i >= 0; i--) xfer_bit(cmd[i], q, s);
      xfer_bit(1'b0, busybit, s9);
      s10 = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b0, q, s);
         res[i] = q;
         if (i == 7) begin
            s10 = s;
            // The word in flight was captured already; later changes must not leak in.
            if (perturb) begin
               ch8 = ~ch8;
               ch4 = ~ch4;
            end
         end
      end
   endtask

   task automatic test_reset();
      int c0;
      c0 = cv8;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cs_n = i[0];
         sclk = ~i[0];
         din  = i[1];
         wait_clk(1);
      end
      checks++; if (dout8 !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout8); end
      checks++; if (sstrb8 !== 1'b0) begin failures++; $display("FAIL reset_sstrb got=%b exp=0", sstrb8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
      checks++; if (cb8 !== 8'h00) begin failures++; $display("FAIL reset_ctrl_byte got=%h exp=00", cb8); end
      checks++; if (cv8 - c0 !== 0) begin failures++; $display("FAIL reset_ctrl_valid got=%0d exp=0", cv8 - c0); end
      cs_n = 1'b1; sclk = 1'b0; din = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_single_frame();
      logic [7:0] res;
      logic bb, s9, s10;
      int c0;
      use4 = 1'b0;
      ch8 = 64'h0;
      ch8[31:24] = 8'hA5;
      c0 = cv8;
      begin_frame();
      run_frame(8'hB0, 0, 1'b1, res, bb, s9, s10);
      checks++; if (cv8 - c0 !== 1) begin failures++; $display("FAIL single_ctrl_valid got=%0d exp=1", cv8 - c0); end
      checks++; if (cb8 !== 8'hB0) begin failures++; $display("FAIL single_ctrl_byte got=%h exp=b0", cb8); end
      checks++; if (bb !== 1'b0) begin failures++; $display("FAIL single_busy_bit got=%b exp=0", bb); end
      checks++; if (s9 !== 1'b1) begin failures++; $display("FAIL single_sstrb_high got=%b exp=1", s9); end
      checks++; if (s10 !== 1'b0) begin failures++; $display("FAIL single_sstrb_low got=%b exp=0", s10); end
      checks++; if (res !== 8'hA5) begin failures++; $display("FAIL single_result got=%h exp=a5", res); end
      checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL single_busy_tail got=%b exp=1", busy8); end
      end_frame();
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy8); end
   endtask

   task automatic test_leading_zeros();
      logic [7:0] res;
      logic bb, s9, s10;
      int c0;
      use4 = 1'b0;
      ch8 = 64'h0;
      ch8[7:0] = 8'h3C;
      c0 = cv8;
      begin_frame();
      run_frame(8'h8F, 3, 1'b0, res, bb, s9, s10);
      checks++; if (cv8 - c0 !== 1) begin failures++; $display("FAIL lead_ctrl_valid got=%0d exp=1", cv8 - c0); end
      checks++; if (cb8 !== 8'h8F) begin failures++; $display("FAIL lead_ctrl_byte got=%h exp=8f", cb8); end
      checks++; if (res !== 8'h3C) begin failures++; $display("FAIL lead_result got=%h exp=3c", res); end
      end_frame();
   endtask

   task automatic test_out_of_range();
      logic [7:0] res;
      logic bb, s9, s10;
      use4 = 1'b1;
      ch4 = 32'hFFFF_FFFF;
      begin_frame();
      run_frame(8'hF0, 0, 1'b0, res, bb, s9, s10);
      checks++; if (res !== 8'h00) begin failures++; $display("FAIL oor_result got=%h exp=00", res); end
      checks++; if (cb4 !== 8'hF0) begin failures++; $display("FAIL oor_ctrl_byte got=%h exp=f0", cb4); end
      end_frame();
      use4 = 1'b0;
   endtask

   task automatic test_abort();
      logic [7:0] cmd, res;
      logic q, s, bb, s9, s10;
      use4 = 1'b0;
      ch8 = 64'h0;
      ch8[15:8] = 8'hFF;
      cmd = 8'h90;
      begin_frame();
      for (int i = 7; i >= 0; i--) xfer_bit(cmd[i], q, s);
      xfer_bit(1'b0, q, s);
      for (int i = 0; i < 5; i++) xfer_bit(1'b0, q, s);
      wait_clk(6);
      checks++; if (dout8 !== 1'b1) begin failures++; $display("FAIL abort_dout_before got=%b exp=1", dout8); end
      cs_n = 1'b1;
      wait_clk(SYNC + 2);
      checks++; if (dout8 !== 1'b0) begin failures++; $display("FAIL abort_dout got=%b exp=0", dout8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy8); end
      checks++; if (sstrb8 !== 1'b0) begin failures++; $display("FAIL abort_sstrb got=%b exp=0", sstrb8); end
      wait_clk(6);
      ch8[15:8] = 8'h7E;
      begin_frame();
      run_frame(8'h90, 0, 1'b0, res, bb, s9, s10);
      checks++; if (res !== 8'h7E) begin failures++; $display("FAIL abort_next_result got=%h exp=7e", res); end
      end_frame();
   endtask

   task automatic test_continuous();
      logic [7:0] r1, r2;
      logic bb, s9, s10;
      int c0;
      use4 = 1'b0;
      ch8 = 64'h0;
      ch8[23:16] = 8'h11;
      ch8[39:32] = 8'h22;
      c0 = cv8;
      begin_frame();
      run_frame(8'hA0, 0, 1'b0, r1, bb, s9, s10);
      run_frame(8'hC0, 0, 1'b0, r2, bb, s9, s10);
      checks++; if (cv8 - c0 !== 2) begin failures++; $display("FAIL cont_ctrl_valid got=%0d exp=2", cv8 - c0); end
      checks++; if (r1 !== 8'h11) begin failures++; $display("FAIL cont_result1 got=%h exp=11", r1); end
      checks++; if (r2 !== 8'h22) begin failures++; $display("FAIL cont_result2 got=%h exp=22", r2); end
      checks++; if (cb8 !== 8'hC0) begin failures++; $display("FAIL cont_ctrl_byte got=%h exp=c0", cb8); end
      end_frame();
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] cmd;
      logic q, s;
      use4 = 1'b0;
      cmd = 8'hB0;
      begin_frame();
      for (int i = 7; i >= 0; i--) xfer_bit(cmd[i], q, s);
      xfer_bit(1'b0, q, s);
      xfer_bit(1'b0, q, s);
      rst = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(2);
      checks++; if (cb8 !== 8'h00) begin failures++; $display("FAIL midrst_ctrl_byte got=%h exp=00", cb8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
      // Without a fresh start bit, zero bits must not restart a frame.
      for (int i = 0; i < 3; i++) xfer_bit(1'b0, q, s);
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL midrst_no_restart got=%b exp=0", busy8); end
      end_frame();
   endtask

   initial begin
      rst  = 1'b0;
      cs_n = 1'b1;
      sclk = 1'b0;
      din  = 1'b0;
      ch8  = 64'h0;
      ch4  = 32'h0;
      use4 = 1'b0;
      test_reset();
      test_single_frame();
      test_leading_zeros();
      test_out_of_range();
      test_abort();
      test_continuous();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder for the serial ADC link driven by `adc_fsm`. Presents the ADC side of the interface (CSnot, SCLK, DIN in; DOUT, SSTRB out) on an oversampling system clock. Decodes the 8-bit control byte, selects one of NCH parallel sample words and shifts it out MSB first. Used as an in-fabric ADC emulator for loopback bring-up and as the DUT-side model in `adc_fsm` benches.

## Interface
- `DATA_W`, 8: conversion result width in bits.
- `NCH`, 8: number of selectable channels (SEL field is 3 bits).
- `SYNC_STAGES`, 2: synchronizer depth on CSnot, SCLK and DIN (≥2).
- `clk`  in  1  system clock; must be ≥ 8× SCLK frequency.
- `rst`  in  1  reset, synchronous, active-low.
- `CSnot`  in  1  chip select from master, active-low.
- `SCLK`  in  1  serial clock from master, idle low.
- `DIN`  in  1  serial command from master.
- `DOUT`  out  1  serial result to master.
- `SSTRB`  out  1  conversion strobe to master.
- `ch_data`  in  NCH*DATA_W  sample words; channel k at bits [k*DATA_W +: DATA_W].
- `ctrl_byte`  out  8  last accepted control byte.
- `ctrl_valid`  out  1  one-clk pulse when `ctrl_byte` updates.
- `busy`  out  1  high from start-bit acceptance until return to IDLE.

## Operation
- CSnot, SCLK, DIN pass through SYNC_STAGES flops; rise/fall of SCLK detected by comparing the last two synchronized samples.
- DIN is sampled on detected SCLK rise; DOUT/SSTRB update on detected SCLK fall.
- Control byte, MSB first: bit7 START (=1), bits6:4 SEL, bit3 UNI/BIP, bit2 SGL/DIF, bits1:0 PD. Only SEL affects behaviour; all bits reported on `ctrl_byte`.
- States:
  - IDLE: DOUT=0, SSTRB=0, busy=0. Rise with CSnot low and DIN=1 → CTRL, bit count=1, shift reg={1}. DIN=0 rises ignored (leading zeros).
  - CTRL: shift DIN on each rise. On 8th bit: `ctrl_byte` loads, `ctrl_valid` pulses in that same cycle → WAIT.
  - WAIT: on next fall: load data shift reg with ch_data[SEL] (0 if SEL ≥ NCH), SSTRB=1, DOUT=0 (busy bit) → DATA.
  - DATA: on each fall, SSTRB=0 and DOUT=next result bit MSB first; after DATA_W bits driven, next fall → TAIL, DOUT=0.
  - TAIL: DOUT=0. Rise with DIN=1 → CTRL (continuous conversion, bit count=1); DIN=0 rises ignored.
- Synchronized CSnot high in any state → IDLE next clk; DOUT=0, SSTRB=0, busy=0; `ctrl_byte` keeps its value.
- ch_data is sampled once, at the WAIT→DATA fall; later changes do not affect the word in flight.

## Timing
- Reset (rst=0 on a clk edge): state IDLE, DOUT=0, SSTRB=0, busy=0, ctrl_valid=0, ctrl_byte=8'h00, synchronizers cleared to CSnot=1, SCLK=0, DIN=0.
- Pin-to-detection latency: SYNC_STAGES+1 clk. DOUT/SSTRB register one clk after fall detection, so DOUT is valid SYNC_STAGES+2 clk after the master's SCLK fall. The master samples DOUT on the following rise.
- Frame: 8 rises command, then 1 fall busy bit (SSTRB high one SCLK period), then DATA_W falls of data, i.e. result MSB is sampled by the master on the 10th SCLK rise of the frame.
- `busy` rises in the clk after the start-bit rise is detected.
- CSnot rise and SCLK edge detected in the same clk: CSnot wins, the edge is discarded.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh start bit.

## Test plan
- Reset: hold rst=0 for 4 clk with pins toggling → DOUT=0, SSTRB=0, busy=0, ctrl_byte=00, no ctrl_valid.
- Single frame: ch_data[3]=8'hA5, control 8'hB0 (SEL=3) → ctrl_valid one pulse, ctrl_byte=B0, SSTRB high one SCLK period after 8th bit, master reads 1010_0101.
- Leading zeros: three 0 bits then 8'h8F (SEL=0, ch_data[0]=8'h3C) → zeros ignored, result 8'h3C.
- Out-of-range channel: NCH=4, control 8'hF0 (SEL=7) → result 8'h00, ctrl_byte=F0.
- Abort: CSnot high after 5th DATA bit → IDLE within SYNC_STAGES+2 clk, DOUT=0, busy=0. Next frame with 8'h90 and ch_data[1]=8'h7E returns 8'h7E.
- Continuous: in TAIL, send 8'hA0 then 8'hC0 without raising CSnot (ch_data[2]=11, ch_data[4]=22) → two ctrl_valid pulses, results 8'h11 then 8'h22.
